// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - funct3 encodings, responder state type and funct3 legality check
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - byte-lane alignment for RISC-V load/store sizes
//   funct3     : load/store size and signedness
//   addr_lo    : byte offset within the word
//   wdata      : store data, low byte/half/word significant
//   raw_word   : word read from memory at the access address
//   byte_en    : lanes written by a store
//   wdata_lane : store data shifted onto its lanes
//   rdata_ext  : sign/zero-extended load data
//   misalign   : half not on even address, or word not on word boundary
module ls_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_en    = 4'b0000;
        rdata_ext  = 32'd0;
        misalign   = 1'b0;
        wdata_lane = wdata << {addr_lo, 3'b000};
        sel_byte   = raw_word[{addr_lo, 3'b000} +: 8];
        sel_half   = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << addr_lo;
                rdata_ext = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                rdata_ext = {24'd0, sel_byte};
            end
            F3_H: begin
                byte_en   = 4'b0011 << addr_lo;
                misalign  = addr_lo[0];
                rdata_ext = {{16{sel_half[15]}}, sel_half};
            end
            F3_HU: begin
                byte_en   = 4'b0011 << addr_lo;
                misalign  = addr_lo[0];
                rdata_ext = {16'd0, sel_half};
            end
            F3_W: begin
                byte_en   = 4'b1111;
                misalign  = (addr_lo != 2'b00);
                rdata_ext = raw_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with byte/half/word access
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_funct3  : request fields
//   resp_valid/resp_ready  : response handshake
//   resp_rdata, resp_err   : load data (0 for stores/errors), error flag
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;

    // With zero wait states the access commits on the accept edge, before
    // anything is latched, so the access path reads the live request in IDLE.
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_funct3;
    logic [IDX_W-1:0] acc_idx;
    logic        acc_err;
    logic        in_range;
    logic        commit;
    logic        mem_we;

    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic [31:0] raw_word;

    assign req_ready  = (state == IDLE);
    assign acc_write  = (state == IDLE) ? req_write  : lat_write;
    assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
    assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
    assign acc_idx    = acc_addr[IDX_W+1:2];
    assign in_range   = (32'(acc_addr[31:2]) < DEPTH_LIM);
    assign acc_err    = !funct3_legal(acc_write, acc_funct3) || misalign || !in_range;
    // Gating with reset keeps a store that is reset on its commit edge from landing.
    assign commit     = !reset && (state != RESP) && (state_next == RESP);
    assign mem_we     = commit && acc_write && !acc_err;

    ls_align u_align (
        .funct3     (acc_funct3),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        always_ff @(posedge clk) begin
            if (mem_we && byte_en[g]) begin
                mem[acc_idx] <= wdata_lane[8*g +: 8];
            end
        end
        assign raw_word[8*g +: 8] = mem[acc_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_write  <= req_write;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
                wait_cnt   <= CNT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_write) ? 32'd0 : rdata_ext;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (WAIT_CYCLES 2 and 0)
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          busy      [2];
    int          exp_first [2];
    logic [31:0] exp_rd    [2];
    logic        exp_err   [2];
    logic [7:0]  model_mem [2][1024];
    bit          ev_mon;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Memory seen as a flat byte array; the access rules are applied directly.
    function automatic void model_exp(input int d, input logic wr, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [2:0] f3, input bit commit,
                                      output logic err, output logic [31:0] rd);
        int size;
        bit sgn;
        bit legal;
        size = 1; sgn = 1'b0; legal = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; legal = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; legal = 1'b1; end
            3'd2: begin size = 4; legal = 1'b1; end
            3'd4: begin size = 1; legal = !wr; end
            3'd5: begin size = 2; legal = !wr; end
            default: ;
        endcase
        rd  = 32'd0;
        err = !legal || ((a / 4) >= 256) || ((a % size) != 0);
        if (!err) begin
            if (wr) begin
                if (commit) begin
                    for (int i = 0; i < size; i++) model_mem[d][a + i] = wd[8*i +: 8];
                end
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = model_mem[d][a + i];
                if (sgn && size < 4 && rd[8*size - 1]) begin
                    for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                ev_mon = busy[d] && (cyc >= exp_first[d]);
                chk($sformatf("d%0d cyc%0d req_ready", d, cyc), 32'(req_ready[d]), 32'(!busy[d]));
                chk($sformatf("d%0d cyc%0d resp_valid", d, cyc), 32'(resp_valid[d]), 32'(ev_mon));
                if (ev_mon) begin
                    chk($sformatf("d%0d cyc%0d resp_rdata", d, cyc), resp_rdata[d], exp_rd[d]);
                    chk($sformatf("d%0d cyc%0d resp_err", d, cyc), 32'(resp_err[d]), 32'(exp_err[d]));
                end
            end
        end
    end

    task automatic do_req(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold, input bit rst_wait,
                          input bit chk_lit, input logic [31:0] lit, input string nm);
        logic        e_err;
        logic [31:0] e_rd;
        int          n;
        int          c;
        model_exp(d, wr, a, wd, f3, 1'b0, e_err, e_rd);
        if (chk_lit) chk({nm, " model"}, e_rd, lit);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_funct3[d] = f3;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s accept: got no accept in %0d cycles, want accept", nm, n);
            req_valid[d] = 1'b0;
            return;
        end
        c = cyc;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        busy[d]      = 1'b1;
        exp_first[d] = c + 1 + wait_of(d);
        exp_rd[d]    = e_rd;
        exp_err[d]   = e_err;
        if (rst_wait) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset   = 1'b0;
            busy[d] = 1'b0;
            return;
        end
        while (cyc < exp_first[d]) begin
            @(posedge clk); #1;
        end
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = (h % 2 == 0);
            req_wdata[d] = $urandom;
            req_addr[d]  = {22'd0, 8'($urandom), 2'b00};
            @(posedge clk); #1;
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        busy[d]       = 1'b0;
        model_exp(d, wr, a, wd, f3, 1'b1, e_err, e_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_funct3[d] = 3'd0; resp_ready[d] = 1'b0;
            busy[d] = 1'b0; exp_first[d] = 0; exp_rd[d] = 32'd0; exp_err[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("d%0d reset resp_rdata", d), resp_rdata[d], 32'd0);
            chk($sformatf("d%0d reset resp_err", d), 32'(resp_err[d]), 32'd0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;

        // WAIT_CYCLES = 2
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 1'b0, 1'b1, 32'd0,        "sw_10");
        do_req(0, 1'b0, 32'h10, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'hDEADBEEF, "lw_10");
        do_req(0, 1'b1, 32'h13, 32'h00000080, 3'd0, 0, 1'b0, 1'b1, 32'd0,        "sb_13");
        do_req(0, 1'b0, 32'h13, 32'd0,        3'd0, 0, 1'b0, 1'b1, 32'hFFFFFF80, "lb_13");
        do_req(0, 1'b0, 32'h13, 32'd0,        3'd4, 0, 1'b0, 1'b1, 32'h00000080, "lbu_13");
        do_req(0, 1'b0, 32'h10, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'h80ADBEEF, "lw_10b");
        do_req(0, 1'b0, 32'h12, 32'd0,        3'd5, 0, 1'b0, 1'b1, 32'h000080AD, "lhu_12");
        do_req(0, 1'b0, 32'h11, 32'd0,        3'd1, 0, 1'b0, 1'b1, 32'd0,        "lh_11_err");
        do_req(0, 1'b1, 32'h12, 32'h55555555, 3'd2, 0, 1'b0, 1'b0, 32'd0,        "sw_12_err");
        do_req(0, 1'b0, 32'h10, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'h80ADBEEF, "lw_10c");
        do_req(0, 1'b0, 32'h400, 32'd0,       3'd2, 0, 1'b0, 1'b1, 32'd0,        "lw_400_err");
        do_req(0, 1'b0, 32'h10, 32'd0,        3'd3, 0, 1'b0, 1'b1, 32'd0,        "ld_f3_err");
        do_req(0, 1'b1, 32'h10, 32'h12345678, 3'd4, 0, 1'b0, 1'b0, 32'd0,        "st_f4_err");
        do_req(0, 1'b0, 32'h10, 32'd0,        3'd2, 5, 1'b0, 1'b1, 32'h80ADBEEF, "lw_10_hold");
        do_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2, 0, 1'b0, 1'b0, 32'd0,        "sw_20");
        do_req(0, 1'b1, 32'h20, 32'h11223344, 3'd2, 0, 1'b1, 1'b0, 32'd0,        "sw_20_rst");
        do_req(0, 1'b0, 32'h20, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'hCAFEF00D, "lw_20");
        do_req(0, 1'b0, 32'h22, 32'd0,        3'd1, 0, 1'b0, 1'b1, 32'hFFFFCAFE, "lh_22");
        do_req(0, 1'b0, 32'h20, 32'd0,        3'd5, 0, 1'b0, 1'b1, 32'h0000F00D, "lhu_20");

        // WAIT_CYCLES = 0
        do_req(1, 1'b1, 32'h3FC, 32'hA5A51234, 3'd2, 0, 1'b0, 1'b0, 32'd0,        "z_sw_3fc");
        do_req(1, 1'b0, 32'h3FD, 32'd0,        3'd0, 0, 1'b0, 1'b1, 32'h00000012, "z_lb_3fd");
        do_req(1, 1'b0, 32'h3FE, 32'd0,        3'd1, 0, 1'b0, 1'b1, 32'hFFFFA5A5, "z_lh_3fe");
        do_req(1, 1'b0, 32'h3FF, 32'd0,        3'd4, 0, 1'b0, 1'b1, 32'h000000A5, "z_lbu_3ff");
        do_req(1, 1'b0, 32'h3FC, 32'd0,        3'd2, 3, 1'b0, 1'b1, 32'hA5A51234, "z_lw_hold");
        do_req(1, 1'b0, 32'h3FE, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'd0,        "z_lw_mis");
        do_req(1, 1'b1, 32'h3FD, 32'h000000EE, 3'd0, 0, 1'b0, 1'b0, 32'd0,        "z_sb_3fd");
        do_req(1, 1'b0, 32'h3FC, 32'd0,        3'd2, 0, 1'b0, 1'b1, 32'hA5A5EE34, "z_lw_3fc");

        repeat (3) @(posedge clk);
        #1 mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
